// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx
//   Sink end of the SID audio output path. Holds one pending signed 16-bit
//   stereo sample and serialises it to an external I2S DAC, MSB first, left
//   word in slots 0..15 and right word in slots 16..31 of a 32-slot frame.
//   A one-cycle oFrame pulse on every frame load acts as the sample-rate
//   clock enable for the upstream filter chain.
//
// Parameters
//   CLK_DIV    clk cycles per BCLK half-period (>= 2).
//
// Ports
//   clk        system clock, all logic on posedge
//   rstn       synchronous active-low reset
//   iLeft      signed left sample
//   iRight     signed right sample
//   iValid     one-cycle capture strobe for iLeft/iRight
//   oFrame     one-cycle pulse on each frame load (sample request)
//   oBclk      I2S bit clock
//   oLrclk     I2S word select, 0 = left
//   oSdata     I2S serial data, MSB first
//   oUnderrun  one-cycle pulse: a frame loaded with no new sample
//   oOverrun   one-cycle pulse: a pending sample was overwritten unconsumed
//
// Configuration macro
//   I2S_LEFT_JUSTIFIED_EN  when defined, word select changes together with
//                          the MSB (left-justified) instead of one BCLK early.

module i2s_sample_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] iLeft,
  input  logic [15:0] iRight,
  input  logic        iValid,
  output logic        oFrame,
  output logic        oBclk,
  output logic        oLrclk,
  output logic        oSdata,
  output logic        oUnderrun,
  output logic        oOverrun
);

  localparam int          DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);

  logic [DW-1:0] div_q,       div_d;
  logic          bclk_q,      bclk_d;
  logic [4:0]    slot_q,      slot_d;
  logic [31:0]   shift_q,     shift_d;
  logic [31:0]   last_q,      last_d;
  logic [15:0]   pendL_q,     pendL_d;
  logic [15:0]   pendR_q,     pendR_d;
  logic          pendValid_q, pendValid_d;
  logic          lrclk_q,     lrclk_d;
  logic          sdata_q,     sdata_d;
  logic          frame_q,     frame_d;
  logic          underrun_q,  underrun_d;
  logic          overrun_q,   overrun_d;

  logic          divWrap;
  logic          fallEv;
  logic          loadEv;
  logic [4:0]    slotNext;
  logic          lrNext;
  logic [31:0]   loadWord;

  // Word select for the slot being entered. Standard I2S leads the data by
  // one BCLK, so it looks one slot ahead.
`ifdef I2S_LEFT_JUSTIFIED_EN
  assign lrNext = slotNext[4];
`else
  logic [4:0] slotAhead;
  assign slotAhead = slotNext + 5'd1;
  assign lrNext    = slotAhead[4];
`endif

  assign divWrap  = (div_q == DIV_MAX);
  assign fallEv   = divWrap & bclk_q;
  assign slotNext = slot_q + 5'd1;
  assign loadEv   = fallEv & (slotNext == 5'd0);
  // With nothing pending, the previous word is repeated rather than muting.
  assign loadWord = pendValid_q ? {pendL_q, pendR_q} : last_q;

  // Next-state logic: BCLK divider, slot/shift sequencing, frame load and
  // sample capture. Capture coincident with a load lands in the freshly
  // emptied holding register, so it is not an overrun.
  always_comb begin
    div_d       = div_q + DIV_ONE;
    bclk_d      = bclk_q;
    slot_d      = slot_q;
    shift_d     = shift_q;
    last_d      = last_q;
    pendL_d     = pendL_q;
    pendR_d     = pendR_q;
    pendValid_d = pendValid_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    frame_d     = 1'b0;
    underrun_d  = 1'b0;
    overrun_d   = 1'b0;

    if (divWrap) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end

    if (fallEv) begin
      slot_d  = slotNext;
      lrclk_d = lrNext;
      if (loadEv) begin
        // The loaded MSB bypasses straight to the output for slot 0.
        shift_d     = loadWord;
        last_d      = loadWord;
        sdata_d     = loadWord[31];
        frame_d     = 1'b1;
        underrun_d  = ~pendValid_q;
        pendValid_d = 1'b0;
      end else begin
        shift_d = {shift_q[30:0], 1'b0};
        sdata_d = shift_q[30];
      end
    end

    if (iValid) begin
      pendL_d     = iLeft;
      pendR_d     = iRight;
      pendValid_d = 1'b1;
      overrun_d   = pendValid_q & ~loadEv;
    end
  end

  // State register with synchronous active-low reset; reset aborts any
  // frame in progress and clears both the pending and last-sent words.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      slot_q      <= 5'd31;
      shift_q     <= '0;
      last_q      <= '0;
      pendL_q     <= '0;
      pendR_q     <= '0;
      pendValid_q <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      frame_q     <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      slot_q      <= slot_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      pendL_q     <= pendL_d;
      pendR_q     <= pendR_d;
      pendValid_q <= pendValid_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign oFrame    = frame_q;
  assign oBclk     = bclk_q;
  assign oLrclk    = lrclk_q;
  assign oSdata    = sdata_q;
  assign oUnderrun = underrun_q;
  assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx
//   Self-checking bench for i2s_sample_tx with CLK_DIV=4. Acts as the DAC:
//   samples oSdata/oLrclk on BCLK rising edges and compares each frame
//   against hand-computed words, plus reset, timing, overrun and
//   capture-on-load corner cases.

module tb_i2s_sample_tx;

  localparam int CLK_DIV = 4;

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam logic [31:0] LR_EXP = 32'hFFFF_0000;
`else
  localparam logic [31:0] LR_EXP = 32'h7FFF_8000;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] iLeft = '0;
  logic [15:0] iRight = '0;
  logic        iValid = 1'b0;
  logic        oFrame, oBclk, oLrclk, oSdata, oUnderrun, oOverrun;

  int checks = 0;
  int errors = 0;
  int ovCount = 0;

  typedef struct {
    int          nValid;
    logic [15:0] l0, r0, l1, r1;
    logic [15:0] expL, expR;
    logic        expUnder;
    int          expOv;
  } vec_t;

  vec_t vecs[6];

  i2s_sample_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .iLeft     (iLeft),
    .iRight    (iRight),
    .iValid    (iValid),
    .oFrame    (oFrame),
    .oBclk     (oBclk),
    .oLrclk    (oLrclk),
    .oSdata    (oSdata),
    .oUnderrun (oUnderrun),
    .oOverrun  (oOverrun)
  );

  always #5 clk = ~clk;

  // Overrun pulses are counted on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (oOverrun === 1'b1) ovCount++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  task automatic waitFrame(output logic under, output int cyc);
    under = 1'b0;
    cyc = 0;
    while (cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (oFrame === 1'b1) begin
        under = oUnderrun;
        return;
      end
    end
    timeoutFail("waitFrame");
  endtask

  task automatic waitRise(output int cyc);
    logic p;
    bit   seen;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 64) begin
      p = oBclk;
      @(negedge clk);
      cyc++;
      if (p === 1'b0 && oBclk === 1'b1) seen = 1;
    end
    if (!seen) timeoutFail("waitRise");
  endtask

  // Read one frame starting just after the oFrame pulse was observed.
  task automatic readBits(output logic [15:0] l, output logic [15:0] r, output logic [31:0] lrs);
    logic [31:0] w;
    int c;
    w = '0;
    lrs = '0;
    for (int i = 0; i < 32; i++) begin
      waitRise(c);
      w[31-i] = oSdata;
      lrs[i]  = oLrclk;
    end
    l = w[31:16];
    r = w[15:0];
  endtask

  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
    iLeft  = l;
    iRight = r;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input int idx);
    logic        u;
    int          c, ovStart;
    logic [15:0] l, r;
    logic [31:0] lrs;
    waitFrame(u, c);
    #1 ovStart = ovCount;
    repeat (3) @(negedge clk);
    if (v.nValid >= 1) applyStimulus(v.l0, v.r0);
    repeat (5) @(negedge clk);
    if (v.nValid >= 2) applyStimulus(v.l1, v.r1);
    waitFrame(u, c);
    #1;
    checkOutput($sformatf("v%0d_overruns", idx), 32'(ovCount - ovStart), 32'(v.expOv));
    checkOutput($sformatf("v%0d_underrun", idx), {31'd0, u}, {31'd0, v.expUnder});
    readBits(l, r, lrs);
    checkOutput($sformatf("v%0d_left", idx), {16'd0, l}, {16'd0, v.expL});
    checkOutput($sformatf("v%0d_right", idx), {16'd0, r}, {16'd0, v.expR});
    checkOutput($sformatf("v%0d_lrclk", idx), lrs, LR_EXP);
  endtask

  initial begin
    logic        u;
    int          c, ovStart;
    logic [15:0] l, r;
    logic [31:0] lrs;

    vecs[0] = '{1, 16'h8001, 16'h7FFE, 16'h0000, 16'h0000, 16'h8001, 16'h7FFE, 1'b0, 0};
    vecs[1] = '{2, 16'h1111, 16'h4444, 16'h2222, 16'h3333, 16'h2222, 16'h3333, 1'b0, 1};
    vecs[2] = '{1, 16'hA5A5, 16'h5A5A, 16'h0000, 16'h0000, 16'hA5A5, 16'h5A5A, 1'b0, 0};
    vecs[3] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5, 16'h5A5A, 1'b1, 0};
    vecs[4] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5, 16'h5A5A, 1'b1, 0};
    vecs[5] = '{1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 1'b0, 0};

    // Reset state.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_bclk", {31'd0, oBclk}, 32'd0);
    checkOutput("rst_lrclk", {31'd0, oLrclk}, 32'd0);
    checkOutput("rst_sdata", {31'd0, oSdata}, 32'd0);
    checkOutput("rst_frame", {31'd0, oFrame}, 32'd0);
    checkOutput("rst_underrun", {31'd0, oUnderrun}, 32'd0);
    checkOutput("rst_overrun", {31'd0, oOverrun}, 32'd0);

    // First frame after release: timing, underrun, zero data.
    rstn = 1'b1;
    waitFrame(u, c);
    checkOutput("first_frame_delay", 32'(c), 32'(2 * CLK_DIV));
    checkOutput("first_underrun", {31'd0, u}, 32'd1);
    readBits(l, r, lrs);
    checkOutput("first_left", {16'd0, l}, 32'd0);
    checkOutput("first_right", {16'd0, r}, 32'd0);
    checkOutput("first_lrclk", lrs, LR_EXP);

    // Idle periods: frame and bit clock.
    waitFrame(u, c);
    waitFrame(u, c);
    checkOutput("frame_period", 32'(c), 32'(64 * CLK_DIV));
    checkOutput("idle_underrun", {31'd0, u}, 32'd1);
    waitRise(c);
    waitRise(c);
    checkOutput("bclk_period", 32'(c), 32'(2 * CLK_DIV));
    #1 checkOutput("idle_no_overrun", 32'(ovCount), 32'd0);

    for (int i = 0; i < 6; i++) runVector(vecs[i], i);

    // Capture on the very edge that loads a frame.
    waitFrame(u, c);
    repeat (3) @(negedge clk);
    applyStimulus(16'h1357, 16'h2468);
    repeat (251) @(negedge clk);
    iLeft  = 16'hCAFE;
    iRight = 16'hBEEF;
    iValid = 1'b1;
    ovStart = ovCount;
    @(negedge clk);
    iValid = 1'b0;
    checkOutput("coinc_frame", {31'd0, oFrame}, 32'd1);
    checkOutput("coinc_underrun", {31'd0, oUnderrun}, 32'd0);
    #1 checkOutput("coinc_no_overrun", 32'(ovCount - ovStart), 32'd0);
    readBits(l, r, lrs);
    checkOutput("coinc_old_left", {16'd0, l}, 32'h1357);
    checkOutput("coinc_old_right", {16'd0, r}, 32'h2468);
    waitFrame(u, c);
    checkOutput("coinc_next_underrun", {31'd0, u}, 32'd0);
    readBits(l, r, lrs);
    checkOutput("coinc_new_left", {16'd0, l}, 32'hCAFE);
    checkOutput("coinc_new_right", {16'd0, r}, 32'hBEEF);

    // Reset in the middle of slot 20 with a sample pending.
    waitFrame(u, c);
    repeat (3) @(negedge clk);
    applyStimulus(16'h1234, 16'h5678);
    repeat (161) @(negedge clk);
    checkOutput("slot20_lrclk", {31'd0, oLrclk}, {31'd0, LR_EXP[20]});
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("midrst_bclk", {31'd0, oBclk}, 32'd0);
    checkOutput("midrst_lrclk", {31'd0, oLrclk}, 32'd0);
    checkOutput("midrst_sdata", {31'd0, oSdata}, 32'd0);
    rstn = 1'b1;
    waitFrame(u, c);
    checkOutput("midrst_restart_delay", 32'(c), 32'(2 * CLK_DIV));
    checkOutput("midrst_underrun", {31'd0, u}, 32'd1);
    readBits(l, r, lrs);
    checkOutput("midrst_left", {16'd0, l}, 32'd0);
    checkOutput("midrst_right", {16'd0, r}, 32'd0);
    checkOutput("midrst_lrclk", lrs, LR_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
